// File: rtl/nios_mulx_sequencer.sv
// Multi-cycle multiply sequencer for the Nios extended ALU path.
// Builds the full 2*WIDTH product from four half-width partial products
// pushed through one registered unsigned multiplier. It then applies the
// signed-operand correction to the high word and hands the selected word
// to writeback over a valid/ready handshake.
module nios_mulx_sequencer #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  localparam int H  = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_FIX   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MULXSS = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MULXSU = OP_W'(3);

  logic [2:0]       state;
  logic [1:0]       count;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic [OP_W-1:0]  op_p0;
  logic [WIDTH-1:0] prod_p1;
  logic [1:0]       shift_p1;
  logic             vld_p1;
  logic [W2-1:0]    acc_p2;
  logic             accept;
  logic [H-1:0]     mul_a, mul_b;
  logic [1:0]       mul_shift;

  // Place a partial product at its weight: 0, H or 2H bits.
  function automatic logic [W2-1:0] align_pp(input logic [WIDTH-1:0] pp,
                                             input logic [1:0] sh);
    logic [W2-1:0] wide;
    wide = W2'(pp);
    case (sh)
      2'd0:    return wide;
      2'd1:    return wide << H;
      default: return wide << (2 * H);
    endcase
  endfunction

  // Turn the unsigned high word into the signed (SS) or signed-by-unsigned
  // (SU) high word by removing the two's-complement cross terms, mod 2^WIDTH.
  function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] hi,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [OP_W-1:0]  op);
    logic [WIDTH-1:0] corr;
    corr = '0;
    if (op == OP_MULXSS)
      corr = (a[WIDTH-1] ? b : '0) + (b[WIDTH-1] ? a : '0);
    else if (op == OP_MULXSU)
      corr = a[WIDTH-1] ? b : '0;
    return hi - corr;
  endfunction

  assign in_ready = !reset && (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != S_IDLE);

  // Pick the operand halves for the partial product selected by count.
  always_comb begin
    mul_a     = a_p0[H-1:0];
    mul_b     = b_p0[H-1:0];
    mul_shift = 2'd0;
    case (count)
      2'd1: begin mul_a = a_p0[WIDTH-1:H]; mul_shift = 2'd1; end
      2'd2: begin mul_b = b_p0[WIDTH-1:H]; mul_shift = 2'd1; end
      2'd3: begin mul_a = a_p0[WIDTH-1:H]; mul_b = b_p0[WIDTH-1:H]; mul_shift = 2'd2; end
      default: ;
    endcase
  end

  // Control FSM with the operand latches and the partial-product counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      count <= 2'd0;
      a_p0  <= '0;
      b_p0  <= '0;
      op_p0 <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          a_p0  <= in_src1;
          b_p0  <= in_src2;
          op_p0 <= in_op;
          count <= 2'd0;
          state <= S_MUL;
        end
        S_MUL: begin
          count <= count + 2'd1;
          if (count == 2'd3) state <= S_DRAIN;
        end
        S_DRAIN: state <= S_FIX;
        S_FIX:   state <= S_DONE;
        S_DONE:  if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: registered half-width multiplier, tagged with its weight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_p1  <= '0;
      shift_p1 <= 2'd0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= (state == S_MUL);
      if (state == S_MUL) begin
        prod_p1  <= WIDTH'(mul_a) * WIDTH'(mul_b);
        shift_p1 <= mul_shift;
      end
    end
  end

  // Stage p2: accumulate each registered product one edge after it lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      acc_p2 <= '0;
    else if (accept)
      acc_p2 <= '0;
    else if (vld_p1)
      acc_p2 <= acc_p2 + align_pp(prod_p1, shift_p1);
  end

  // Output register: load the selected word in FIX and hold it until it is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (state == S_FIX) begin
      out_valid  <= 1'b1;
      out_result <= (op_p0 == OP_MUL) ? acc_p2[WIDTH-1:0]
                  : sign_fix(acc_p2[W2-1:WIDTH], a_p0, b_p0, op_p0);
    end else if (state == S_DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nios_mulx_sequencer.sv
// Directed and randomized bench for nios_mulx_sequencer.
module tb_nios_mulx_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  nios_mulx_sequencer #(.WIDTH(32), .OP_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Issue one op (called #1 after a rising edge), wait for the result,
  // hold out_ready low for 'stall' cycles, then take it.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int stall, output logic [31:0] res, output int lat,
                       output bit ok);
    ok  = 1'b1;
    lat = 0;
    res = '0;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL op_in_ready: got %b want 1", in_ready);
    end
    in_valid  = 1'b1;
    in_op     = op;
    in_src1   = a;
    in_src2   = b;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_src1  = $urandom;
    in_src2  = $urandom;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      ok = 1'b0;
      out_ready = 1'b0;
      $display("FAIL op_timeout: out_valid=%b after %0d clocks, want 1", out_valid, lat);
      return;
    end
    res = out_result;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== res || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL op_hold: valid=%b result=%h ready=%b want 1 %h 0",
                 out_valid, out_result, in_ready, res);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL op_release: valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op     = 2'd0;
    in_src1   = '0;
    in_src2   = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_result=%h busy=%b want 0 0 0 0",
               in_ready, out_valid, out_result, busy);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_mul_vectors();
    logic [1:0]  ops [6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [31:0] va  [6] = '{32'h0001_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002};
    logic [31:0] vb  [6] = '{32'h0002_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] exp [6] = '{32'h000B_000F, 32'hFFFF_FFFE, 32'h0000_0000,
                             32'h4000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
    logic [31:0] res;
    int lat;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], va[i], vb[i], 0, res, lat, ok);
      if (ok) begin
        n_checks++;
        if (res !== exp[i] || lat != 6) begin
          n_fail++;
          $display("FAIL vector%0d: result=%h latency=%0d want %h 6", i, res, lat, exp[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int w = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 2'd1;
    in_src1   = 32'hFFFF_FFFF;
    in_src2   = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFFE || w != 6) begin
      n_fail++;
      $display("FAIL bp_result: valid=%b result=%h latency=%0d want 1 fffffffe 6",
               out_valid, out_result, w);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_op    = 2'd0;
      in_src1  = 32'd7;
      in_src2  = 32'd9;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFFE || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b result=%h in_ready=%b busy=%b want 1 fffffffe 0 1",
                 i, out_valid, out_result, in_ready, busy);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_same_cycle_ready: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b valid=%b result=%h want 1 0 fffffffe",
               in_ready, out_valid, out_result);
    end
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_extra_accept: busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] res;
    int lat;
    bit ok;
    in_valid = 1'b1;
    in_op    = 2'd1;
    in_src1  = 32'h1234_5678;
    in_src2  = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_abort: valid=%b in_ready=%b busy=%b want 0 0 0",
               out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_hold: in_ready=%b busy=%b want 0 0", in_ready, busy);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    do_op(2'd0, 32'd7, 32'd9, 0, res, lat, ok);
    if (ok) begin
      n_checks++;
      if (res !== 32'h0000_003F || lat != 6) begin
        n_fail++;
        $display("FAIL midreset_next_op: result=%h latency=%0d want 0000003f 6", res, lat);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp;
    logic [63:0] ea, eb, prod;
    logic [1:0]  op;
    int lat;
    bit ok;
    for (int i = 0; i < 2000; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      b  = ($urandom_range(0, 4) == 0) ? 32'h7FFF_FFFF : $urandom;
      ea = (op == 2'd2 || op == 2'd3) ? {{32{a[31]}}, a} : {32'h0, a};
      eb = (op == 2'd2) ? {{32{b[31]}}, b} : {32'h0, b};
      prod = ea * eb;
      exp  = (op == 2'd0) ? prod[31:0] : prod[63:32];
      do_op(op, a, b, $urandom_range(0, 3), res, lat, ok);
      if (!ok) break;
      n_checks++;
      if (res !== exp || lat != 6) begin
        n_fail++;
        $display("FAIL random%0d op=%0d a=%h b=%h: result=%h latency=%0d want %h 6",
                 i, op, a, b, res, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_vectors();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
